data_mem_bytelane: RTL and testbench
====================================

Name: data_mem_bytelane

Overview:
- Parametrised successor to the single-port word data RAM used by the single-cycle/pipelined MIPS datapath.
- Adds byte/halfword/word load-store modes with sign/zero extension.
- Adds alignment and range checking, and a synthesizable sequential clear sweep that replaces the one-cycle bulk reset.
- Sits behind the ALU address path; the write log line feeds the course grader.

Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words (default 12 KiB); must be a power of two or any value ≥2.
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.
- LOG_EN, 1, when 1 every accepted write emits one $display line.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- address  in  32  byte address
- storeData  in  32  store source; low bits used for sub-word stores
- MemWrite  in  1  store request this cycle
- memOp  in  3  0=word, 1=half unsigned, 2=half signed, 3=byte unsigned, 4=byte signed, 5-7 reserved
- loadData  out  32  extended load result (combinational)
- busy  out  1  clear sweep in progress
- alignErr  out  1  address misaligned for memOp, or memOp reserved (combinational)
- rangeErr  out  1  address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) (combinational)
- PCForTest  in  32  PC of the storing instruction, used only for the log line

Behaviour:
- Storage: DEPTH_WORDS x 32 words. Word index = (address-BASE_ADDR)>>2; byte offset = address[1:0].
- Byte order is big-endian: offset 0 maps to bits 31:24, offset 3 maps to bits 7:0.
- Halfword offset 0 maps to bits 31:16; offset 2 maps to bits 15:0.
- Alignment rules:
  - word requires address[1:0]==0.
  - half requires address[0]==0.
  - byte is always aligned.
  - reserved memOp sets alignErr=1.
- Range: rangeErr=1 if address<BASE_ADDR or address≥BASE_ADDR+4*DEPTH_WORDS. Compute in 33 bits so no wrap-around aliasing occurs.
- Load path (combinational, zero latency):
  - If busy, alignErr or rangeErr is set, loadData=0.
  - Otherwise select the lane and zero- or sign-extend to 32 bits per memOp.
- Store (posedge clk), accepted only if MemWrite=1 and busy=0 and alignErr=0 and rangeErr=0:
  - Word stores write storeData.
  - Half stores write storeData[15:0] into the selected lane.
  - Byte stores write storeData[7:0] into the selected lane.
  - Other lanes are unchanged.
  - A rejected store leaves memory untouched and emits no log line.
- Log: on an accepted store with LOG_EN=1, print "@%h: *%h <= %h" using PCForTest, the word-aligned address (address&~3), and the full merged word after the store.
- Clear FSM, states CLEAR and IDLE:
  - rst=1 at a posedge sets state=CLEAR and clrIdx=0, and writes word 0 to 0.
  - While rst stays high, the FSM remains at index 0.
  - In CLEAR with rst=0, each cycle writes word clrIdx to 0 and increments clrIdx.
  - After writing word DEPTH_WORDS-1, the FSM moves to IDLE.
- Sweep timing: after rst falls, busy stays high for exactly DEPTH_WORDS cycles, then drops.
- Reset values: busy=1, state=CLEAR, clrIdx=0; loadData=0 while busy. alignErr and rangeErr are purely combinational from the inputs.
- rst asserted mid-sweep or mid-operation restarts the sweep at index 0. A store in the same cycle as rst is dropped.
- Simultaneous MemWrite and a load of the same address: loadData shows the old value; the new value is visible the cycle after the edge.
- clrIdx width is $clog2(DEPTH_WORDS)+1 so the terminal compare cannot wrap.

Test Plan:
- Sweep timing with DEPTH_WORDS=16: hold rst 2 cycles, release -> busy=1 for exactly 16 cycles, then 0. A word load of 0x0 during the sweep returns 0, and every word reads 0 afterward.
- Word store/load: sw 0x12345678 to 0x10 -> log "@<pc>: *00000010 <= 12345678"; lw 0x10 returns 0x12345678.
- Byte merge: after the word store above, sb 0xAB to 0x11 -> log shows 0x12AB5678.
  - lbu 0x11 returns 0x000000AB; lb 0x11 returns 0xFFFFFFAB.
  - lhu 0x12 returns 0x00005678; lh 0x10 returns 0x000012AB.
- Misaligned accesses:
  - sw to 0x12 -> alignErr=1, memory unchanged, no log.
  - lh 0x13 -> alignErr=1, loadData=0.
  - memOp=6 -> alignErr=1.
- Out of range: address=BASE_ADDR+4*DEPTH_WORDS -> rangeErr=1, store dropped, load returns 0. Address 0xFFFFFFFC does not alias to a low word.
- Reset mid-sweep and store during busy:
  - Pulse rst at sweep cycle 5 -> busy persists 16 cycles after the new release.
  - A sw issued during busy is not logged and not stored.

Source files
------------

// File: rtl/data_mem_bytelane.sv
// Byte-lane data RAM for the MIPS datapath: big-endian byte/half/word access,
// alignment and range checks, and a sequential clear sweep after reset.
module data_mem_bytelane #(
    parameter int unsigned DEPTH_WORDS = 3072,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter bit          LOG_EN      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] storeData,
    input  logic        MemWrite,
    input  logic [2:0]  memOp,
    output logic [31:0] loadData,
    output logic        busy,
    output logic        alignErr,
    output logic        rangeErr,
    input  logic [31:0] PCForTest
);

    localparam int unsigned AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned IDX_W   = $clog2(DEPTH_WORDS) + 1;
    localparam logic [32:0] BASE33  = {1'b0, BASE_ADDR};
    localparam logic [32:0] LIMIT33 = BASE33 + 33'(4 * DEPTH_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

    localparam logic [2:0] OP_WORD = 3'd0;
    localparam logic [2:0] OP_HU   = 3'd1;
    localparam logic [2:0] OP_HS   = 3'd2;
    localparam logic [2:0] OP_BU   = 3'd3;
    localparam logic [2:0] OP_BS   = 3'd4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
    logic [31:0]       mem_q [DEPTH_WORDS];

    logic [31:0]       byte_off;
    logic [AW-1:0]     word_idx;
    logic [32:0]       addr33;
    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_ext;
    logic [31:0]       merged;
    logic              mem_we;
    logic [AW-1:0]     mem_idx;
    logic [31:0]       mem_wdata;
    logic              store_ok;

    assign busy = (state_q == ST_CLEAR);

    // Address decode; 33-bit compare keeps high addresses from aliasing low words
    always_comb begin
        byte_off = address - BASE_ADDR;
        word_idx = AW'(byte_off >> 2);
        addr33   = {1'b0, address};
        rangeErr = (addr33 < BASE33) || (addr33 >= LIMIT33);
    end

    always_comb begin
        alignErr = 1'b0;
        case (memOp)
            OP_WORD:      alignErr = (address[1:0] != 2'b00);
            OP_HU, OP_HS: alignErr = address[0];
            OP_BU, OP_BS: alignErr = 1'b0;
            default:      alignErr = 1'b1;
        endcase
    end

    // Big-endian lane select and extension
    always_comb begin
        rd_word = mem_q[word_idx];
        rd_half = address[1] ? rd_word[15:0] : rd_word[31:16];
        rd_byte = rd_word[7:0];
        case (address[1:0])
            2'd0:    rd_byte = rd_word[31:24];
            2'd1:    rd_byte = rd_word[23:16];
            2'd2:    rd_byte = rd_word[15:8];
            default: rd_byte = rd_word[7:0];
        endcase
        load_ext = 32'd0;
        case (memOp)
            OP_WORD: load_ext = rd_word;
            OP_HU:   load_ext = {16'd0, rd_half};
            OP_HS:   load_ext = {{16{rd_half[15]}}, rd_half};
            OP_BU:   load_ext = {24'd0, rd_byte};
            OP_BS:   load_ext = {{24{rd_byte[7]}}, rd_byte};
            default: load_ext = 32'd0;
        endcase
        loadData = (busy || alignErr || rangeErr) ? 32'd0 : load_ext;
    end

    // Read-modify-write merge of the store into the addressed word
    always_comb begin
        merged = rd_word;
        case (memOp)
            OP_WORD: merged = storeData;
            OP_HU, OP_HS: begin
                if (address[1]) merged[15:0]  = storeData[15:0];
                else            merged[31:16] = storeData[15:0];
            end
            OP_BU, OP_BS: begin
                case (address[1:0])
                    2'd0:    merged[31:24] = storeData[7:0];
                    2'd1:    merged[23:16] = storeData[7:0];
                    2'd2:    merged[15:8]  = storeData[7:0];
                    default: merged[7:0]   = storeData[7:0];
                endcase
            end
            default: merged = rd_word;
        endcase
    end

    // Clear FSM and memory write arbitration; reset and sweep own the write port
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        mem_we    = 1'b0;
        mem_idx   = word_idx;
        mem_wdata = merged;
        store_ok  = 1'b0;
        if (rst) begin
            state_d   = ST_CLEAR;
            clr_idx_d = '0;
            mem_we    = 1'b1;
            mem_idx   = '0;
            mem_wdata = 32'd0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    mem_we    = 1'b1;
                    mem_idx   = AW'(clr_idx_q);
                    mem_wdata = 32'd0;
                    clr_idx_d = clr_idx_q + IDX_W'(1);
                    if (clr_idx_q == LAST_IDX) state_d = ST_IDLE;
                end
                default: begin
                    if (MemWrite && !alignErr && !rangeErr) begin
                        mem_we   = 1'b1;
                        store_ok = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_idx] <= mem_wdata;
    end

    // Grader log line for every accepted store
    generate
        if (LOG_EN) begin : g_log
            always @(posedge clk) begin
                if (store_ok)
                    $display("@%h: *%h <= %h", PCForTest, {address[31:2], 2'b00}, mem_wdata);
            end
        end
    endgenerate

endmodule

// File: tb/tb_data_mem_bytelane.sv
// Directed self-checking bench for data_mem_bytelane with a 16-word memory.
module tb_data_mem_bytelane;

    logic        clk;
    logic        rst;
    logic [31:0] address;
    logic [31:0] storeData;
    logic        MemWrite;
    logic [2:0]  memOp;
    logic [31:0] loadData;
    logic        busy;
    logic        alignErr;
    logic        rangeErr;
    logic [31:0] PCForTest;

    int checks;
    int failures;
    int cnt;

    data_mem_bytelane #(
        .DEPTH_WORDS(16),
        .BASE_ADDR  (32'h0000_0000),
        .LOG_EN     (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .address  (address),
        .storeData(storeData),
        .MemWrite (MemWrite),
        .memOp    (memOp),
        .loadData (loadData),
        .busy     (busy),
        .alignErr (alignErr),
        .rangeErr (rangeErr),
        .PCForTest(PCForTest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [31:0] a, input logic [2:0] op,
                         input logic we, input logic [31:0] d);
        address   = a;
        memOp     = op;
        MemWrite  = we;
        storeData = d;
        PCForTest = 32'h0040_0000 + a;
        #1;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        address   = 32'd0;
        storeData = 32'd0;
        MemWrite  = 1'b0;
        memOp     = 3'd0;
        PCForTest = 32'd0;

        // Reset held two cycles, then the sweep
        tick();
        tick();
        apply(32'h0, 3'd0, 1'b0, 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd1);
        check_eq("reset_load0", loadData, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("sweep_load0", loadData, 32'd0);
        count_busy(cnt);
        check_eq("sweep_cycles", 32'(cnt), 32'd16);
        check_eq("busy_after_sweep", 32'(busy), 32'd0);
        for (int i = 0; i < 16; i++) begin
            apply(32'(i * 4), 3'd0, 1'b0, 32'd0);
            check_eq($sformatf("cleared_w%0d", i), loadData, 32'd0);
        end

        // Word store; load of the same address shows the old value before the edge
        apply(32'h10, 3'd0, 1'b1, 32'h1234_5678);
        check_eq("sw_old_value", loadData, 32'd0);
        tick();
        apply(32'h10, 3'd0, 1'b0, 32'd0);
        check_eq("lw_10", loadData, 32'h1234_5678);

        // Byte merge and sub-word loads
        apply(32'h11, 3'd3, 1'b1, 32'hFFFF_FFAB);
        tick();
        apply(32'h10, 3'd0, 1'b0, 32'd0);
        check_eq("sb_merge", loadData, 32'h12AB_5678);
        apply(32'h11, 3'd3, 1'b0, 32'd0);
        check_eq("lbu_11", loadData, 32'h0000_00AB);
        apply(32'h11, 3'd4, 1'b0, 32'd0);
        check_eq("lb_11", loadData, 32'hFFFF_FFAB);
        apply(32'h12, 3'd1, 1'b0, 32'd0);
        check_eq("lhu_12", loadData, 32'h0000_5678);
        apply(32'h10, 3'd2, 1'b0, 32'd0);
        check_eq("lh_10", loadData, 32'h0000_12AB);
        apply(32'h13, 3'd4, 1'b0, 32'd0);
        check_eq("lb_13", loadData, 32'h0000_0078);
        apply(32'h10, 3'd4, 1'b0, 32'd0);
        check_eq("lb_10", loadData, 32'h0000_0012);

        // Halfword store to the low lane, then signed reload
        apply(32'h12, 3'd1, 1'b1, 32'h0000_BEEF);
        tick();
        apply(32'h10, 3'd0, 1'b0, 32'd0);
        check_eq("sh_merge", loadData, 32'h12AB_BEEF);
        apply(32'h12, 3'd2, 1'b0, 32'd0);
        check_eq("lh_12", loadData, 32'hFFFF_BEEF);

        // Misaligned and reserved accesses
        apply(32'h12, 3'd0, 1'b1, 32'hDEAD_BEEF);
        check_eq("sw_12_align", 32'(alignErr), 32'd1);
        check_eq("sw_12_load", loadData, 32'd0);
        tick();
        apply(32'h10, 3'd0, 1'b0, 32'd0);
        check_eq("sw_12_dropped", loadData, 32'h12AB_BEEF);
        check_eq("lw_10_align", 32'(alignErr), 32'd0);
        apply(32'h13, 3'd2, 1'b0, 32'd0);
        check_eq("lh_13_align", 32'(alignErr), 32'd1);
        check_eq("lh_13_load", loadData, 32'd0);
        apply(32'h10, 3'd6, 1'b0, 32'd0);
        check_eq("op6_align", 32'(alignErr), 32'd1);
        check_eq("op6_load", loadData, 32'd0);
        apply(32'h13, 3'd3, 1'b0, 32'd0);
        check_eq("lbu_13_align", 32'(alignErr), 32'd0);

        // Range boundary and high-address aliasing
        apply(32'h3C, 3'd0, 1'b0, 32'd0);
        check_eq("last_word_range", 32'(rangeErr), 32'd0);
        apply(32'h40, 3'd0, 1'b1, 32'hDEAD_BEEF);
        check_eq("limit_range", 32'(rangeErr), 32'd1);
        check_eq("limit_load", loadData, 32'd0);
        tick();
        apply(32'hFFFF_FFFC, 3'd0, 1'b1, 32'hCAFE_F00D);
        check_eq("high_range", 32'(rangeErr), 32'd1);
        check_eq("high_load", loadData, 32'd0);
        tick();
        apply(32'h0, 3'd0, 1'b0, 32'd0);
        check_eq("no_alias_w0", loadData, 32'd0);
        apply(32'h3C, 3'd0, 1'b0, 32'd0);
        check_eq("no_alias_w15", loadData, 32'd0);

        // Reset mid-sweep, and a store attempted while busy
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check_eq("midsweep_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cnt = 0;
        while (busy && cnt < 100) begin
            if (cnt == 12) apply(32'h20, 3'd0, 1'b1, 32'h0000_0055);
            else if (cnt == 13) apply(32'h20, 3'd0, 1'b0, 32'd0);
            tick();
            cnt++;
        end
        check_eq("restart_cycles", 32'(cnt), 32'd16);
        apply(32'h20, 3'd0, 1'b0, 32'd0);
        check_eq("busy_store_dropped", loadData, 32'd0);
        apply(32'h10, 3'd0, 1'b0, 32'd0);
        check_eq("resweep_cleared", loadData, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
